// File: rtl/gfx_bus_pkg.sv
// Shared bus types for the graphics bus switch and its device responders.
package gfx_bus_pkg;

  // Command codes carried on cmdin/cmdout.
  typedef enum logic [2:0] {
    CMD_IDLE    = 3'd0,
    CMD_READ    = 3'd1,
    CMD_WRITE   = 3'd2,
    CMD_RD_RESP = 3'd3,
    CMD_WR_ACK  = 3'd4,
    CMD_ERR     = 3'd5
  } cmd_e;

  // Target-side protocol states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_RDRESP,
    ST_RESP,
    ST_GAP
  } tgt_state_e;

  localparam logic [3:0] RESP_TAR = 4'hF;
  localparam logic [1:0] REQ_ON   = 2'b01;
  localparam logic [1:0] REQ_OFF  = 2'b00;

  // True for the commands a target accepts from the switch.
  function automatic logic is_request(input cmd_e c);
    return (c == CMD_READ) || (c == CMD_WRITE);
  endfunction

endpackage

// File: rtl/gfx_bus_if.sv
// Switch <-> target bus bundle. master = switch side, slave = device responder.
interface gfx_bus_if;
  import gfx_bus_pkg::*;

  logic        selin;
  cmd_e        cmdin;
  logic [31:0] addrdatain;
  logic [1:0]  lenin;
  logic        ackin;
  logic [1:0]  reqout;
  logic [3:0]  reqtar;
  cmd_e        cmdout;
  logic [31:0] addrdataout;
  logic [1:0]  lenout;

  modport master (
    output selin, cmdin, addrdatain, lenin, ackin,
    input  reqout, reqtar, cmdout, addrdataout, lenout
  );

  modport slave (
    input  selin, cmdin, addrdatain, lenin, ackin,
    output reqout, reqtar, cmdout, addrdataout, lenout
  );

endinterface

// File: rtl/gfx_regbank.sv
// Register bank: one synchronous write port, two asynchronous read ports.
module gfx_regbank #(
  parameter int unsigned NWORDS = 64,
  parameter int unsigned DW     = 32,
  localparam int unsigned AW    = $clog2(NWORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b
);

  logic [DW-1:0] r_mem [NWORDS];

  // Bank storage: cleared on reset, one word written per cycle.
  // NOTE: the bank must come up cleared, so every word carries a reset; this keeps it as flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NWORDS); i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write shows up next cycle.
  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/gfx_bus_target.sv
// Slave-side responder for one graphics device on the bus switch.
// Decodes READ/WRITE bursts into its register bank and returns one response
// beat at a time, each followed by a single idle gap cycle.
module gfx_bus_target
  import gfx_bus_pkg::*;
#(
  parameter int unsigned DEV_ID = 0,
  parameter logic [31:0] BASE   = 32'hF000_0000,
  parameter int unsigned NWORDS = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  gfx_bus_if.slave                  bus,
  output logic                      busy,
  input  logic [$clog2(NWORDS)-1:0] disp_idx,
  output logic [31:0]               disp_data
);

  localparam int unsigned IDX_W   = $clog2(NWORDS);
  localparam logic [31:0] WINDOW  = BASE + 32'(DEV_ID) * 32'h100;
  localparam logic [IDX_W:0] IDX_MAX = (IDX_W + 1)'(NWORDS - 1);

  tgt_state_e       r_state, w_state_nxt;
  logic [31:0]      r_addr;
  logic [1:0]       r_len;
  logic [IDX_W-1:0] r_idx;
  logic [2:0]       r_beat;
  logic             r_hit;
  cmd_e             r_resp;

  logic             w_accept;
  logic [IDX_W-1:0] w_in_idx;
  logic             w_in_hit;
  logic [IDX_W-1:0] w_bank_idx;
  logic             w_last_beat;
  logic             w_we;
  logic [31:0]      w_bus_rdata;

  // Request decode: window match, word alignment and in-range burst end.
  assign w_accept    = (r_state == ST_IDLE) && bus.selin && is_request(bus.cmdin);
  assign w_in_idx    = bus.addrdatain[IDX_W+1:2];
  assign w_in_hit    = (bus.addrdatain[31:8] == WINDOW[31:8]) &&
                       (bus.addrdatain[1:0] == 2'b00) &&
                       (({1'b0, w_in_idx} + {{(IDX_W-1){1'b0}}, bus.lenin}) <= IDX_MAX);
  // The accept-time range check guarantees idx+beat never wraps on a hit.
  assign w_bank_idx  = r_idx + IDX_W'(r_beat);
  assign w_last_beat = (r_beat == {1'b0, r_len});
  assign w_we        = (r_state == ST_WDATA) && bus.selin && r_hit;

  gfx_regbank #(.NWORDS(NWORDS), .DW(32)) u_bank (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_we),
    .i_waddr   (w_bank_idx),
    .i_wdata   (bus.addrdatain),
    .i_raddr_a (w_bank_idx),
    .o_rdata_a (w_bus_rdata),
    .i_raddr_b (disp_idx),
    .o_rdata_b (disp_data)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  // NOTE: defaults come first so every path assigns every signal and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (bus.cmdin == CMD_WRITE) w_state_nxt = ST_WDATA;
          else if (w_in_hit)          w_state_nxt = ST_RDRESP;
          else                        w_state_nxt = ST_RESP;
        end
      end
      ST_WDATA: begin
        if (!bus.selin || w_last_beat) w_state_nxt = ST_RESP;
      end
      ST_RDRESP, ST_RESP: begin
        if (bus.ackin) w_state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if ((r_resp == CMD_RD_RESP) && (r_beat <= {1'b0, r_len})) w_state_nxt = ST_RDRESP;
        else                                                        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Transaction context: latched at accept, beat counter and response kind updated per beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_len  <= '0;
      r_idx  <= '0;
      r_beat <= '0;
      r_hit  <= 1'b0;
      r_resp <= CMD_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr <= bus.addrdatain;
            r_len  <= bus.lenin;
            r_idx  <= w_in_idx;
            r_beat <= '0;
            r_hit  <= w_in_hit;
            if (bus.cmdin == CMD_WRITE) r_resp <= CMD_WR_ACK;
            else                        r_resp <= w_in_hit ? CMD_RD_RESP : CMD_ERR;
          end
        end
        ST_WDATA: begin
          if (!bus.selin)       r_resp <= CMD_ERR;
          else if (w_last_beat) r_resp <= r_hit ? CMD_WR_ACK : CMD_ERR;
          else                  r_beat <= r_beat + 3'd1;
        end
        ST_RDRESP: begin
          if (bus.ackin) r_beat <= r_beat + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Response outputs: driven only while a beat is pending, zero otherwise.
  always_comb begin
    bus.reqout      = REQ_OFF;
    bus.reqtar      = 4'h0;
    bus.cmdout      = CMD_IDLE;
    bus.addrdataout = '0;
    bus.lenout      = 2'b00;
    if ((r_state == ST_RDRESP) || (r_state == ST_RESP)) begin
      bus.reqout = REQ_ON;
      bus.reqtar = RESP_TAR;
      bus.cmdout = r_resp;
      bus.lenout = r_len;
      if (r_state == ST_RDRESP)     bus.addrdataout = w_bus_rdata;
      else if (r_resp == CMD_WR_ACK) bus.addrdataout = r_addr;
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gfx_bus_target.sv
// Self-checking bench for gfx_bus_target (DEV_ID=1): directed table, corner
// sequences and randomized bursts against a transaction-level bank model.
module tb_gfx_bus_target;
  import gfx_bus_pkg::*;

  localparam logic [31:0] WIN = 32'hF000_0100;  // BASE + 1*0x100

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [5:0] disp_idx;
  logic [31:0] disp_data;

  gfx_bus_if bus();

  gfx_bus_target #(.DEV_ID(1), .BASE(32'hF000_0000), .NWORDS(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .disp_idx  (disp_idx),
    .disp_data (disp_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mem [64];

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [1:0]   len;
    int           nsend;
    logic [127:0] wdata;
    cmd_e         exp_cmd;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_hit(input logic [31:0] a, input logic [1:0] l);
    int unsigned first;
    first = int'(a[7:2]);
    return (a[31:8] == WIN[31:8]) && (a[1:0] == 2'b00) && (first + int'(l) <= 63);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " reqout"}, 32'(bus.reqout), 32'h0);
    check({tag, " reqtar"}, 32'(bus.reqtar), 32'h0);
    check({tag, " cmdout"}, 32'(bus.cmdout), 32'h0);
    check({tag, " data"},   bus.addrdataout, 32'h0);
    check({tag, " lenout"}, 32'(bus.lenout), 32'h0);
    check({tag, " busy"},   32'(busy),       32'h0);
  endtask

  task automatic check_beat(input string tag, input cmd_e c, input logic [31:0] d, input logic [1:0] l);
    check({tag, " reqout"}, 32'(bus.reqout), 32'h1);
    check({tag, " reqtar"}, 32'(bus.reqtar), 32'hF);
    check({tag, " cmdout"}, 32'(bus.cmdout), 32'(c));
    check({tag, " data"},   bus.addrdataout, d);
    check({tag, " lenout"}, 32'(bus.lenout), 32'(l));
  endtask

  task automatic check_disp(input logic [5:0] idx, input logic [31:0] exp);
    disp_idx = idx;
    #1;
    check($sformatf("disp[%0d]", idx), disp_data, exp);
  endtask

  // Full transaction: address beat, data beats, then every response beat acked
  // after ack_dly stall cycles. Expectations are supplied by the caller.
  task automatic do_txn(input string tag, input bit wr, input logic [31:0] addr, input logic [1:0] len,
                        input int nsend, input logic [127:0] wdata, input cmd_e exp_cmd,
                        input logic [127:0] exp_rdata, input int ack_dly);
    int nbeats;
    int nfull;
    logic [31:0] exp_d;
    nfull = int'(len) + 1;
    bus.selin = 1'b1;
    bus.cmdin = wr ? CMD_WRITE : CMD_READ;
    bus.addrdatain = addr;
    bus.lenin = len;
    tick();
    bus.cmdin = CMD_IDLE;
    bus.lenin = 2'b00;
    if (wr) begin
      for (int b = 0; b < nsend; b++) begin
        bus.selin = 1'b1;
        bus.addrdatain = wdata[32*b +: 32];
        tick();
      end
      if (nsend < nfull) begin
        bus.selin = 1'b0;
        tick();
      end
    end
    bus.selin = 1'b0;
    bus.addrdatain = '0;
    if (wr && model_hit(addr, len))
      for (int b = 0; b < nsend && b < nfull; b++) mem[6'(int'(addr[7:2]) + b)] = wdata[32*b +: 32];
    nbeats = (exp_cmd == CMD_RD_RESP) ? nfull : 1;
    for (int b = 0; b < nbeats; b++) begin
      if (exp_cmd == CMD_RD_RESP)     exp_d = exp_rdata[32*b +: 32];
      else if (exp_cmd == CMD_WR_ACK) exp_d = addr;
      else                            exp_d = 32'h0;
      for (int w = 0; w <= ack_dly; w++) begin
        check_beat($sformatf("%s b%0d w%0d", tag, b, w), exp_cmd, exp_d, len);
        if (w < ack_dly) tick();
      end
      bus.ackin = 1'b1;
      tick();
      bus.ackin = 1'b0;
      check($sformatf("%s gap%0d reqout", tag, b), 32'(bus.reqout), 32'h0);
      tick();
    end
    check({tag, " end busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           wr;
    logic [1:0]   len;
    logic [5:0]   idx;
    logic [31:0]  addr;
    int           sel;
    int           nsend;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
    cmd_e         exp_cmd;

    reset = 1'b1;
    bus.selin = 1'b0;
    bus.cmdin = CMD_IDLE;
    bus.addrdatain = '0;
    bus.lenin = '0;
    bus.ackin = 1'b0;
    disp_idx = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    #1;
    check_idle_outputs("in_reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_idle_outputs("after_reset");
    check_disp(6'd0, 32'h0);

    vecs[0]  = '{1'b1, 32'hF000_0104, 2'd0, 1, 128'hDEAD_BEEF, CMD_WR_ACK, 128'h0};
    vecs[1]  = '{1'b1, 32'hF000_0110, 2'd3, 4, {32'd4, 32'd3, 32'd2, 32'd1}, CMD_WR_ACK, 128'h0};
    vecs[2]  = '{1'b0, 32'hF000_0110, 2'd3, 0, 128'h0, CMD_RD_RESP, {32'd4, 32'd3, 32'd2, 32'd1}};
    vecs[3]  = '{1'b0, 32'hF000_0200, 2'd0, 0, 128'h0, CMD_ERR, 128'h0};
    vecs[4]  = '{1'b1, 32'hF000_01FC, 2'd1, 2, {32'hAAAA_0002, 32'hAAAA_0001}, CMD_ERR, 128'h0};
    vecs[5]  = '{1'b0, 32'hF000_01FC, 2'd0, 0, 128'h0, CMD_RD_RESP, 128'h0};
    vecs[6]  = '{1'b1, 32'hF000_0102, 2'd0, 1, 128'h1111_1111, CMD_ERR, 128'h0};
    vecs[7]  = '{1'b0, 32'hF000_0104, 2'd0, 0, 128'h0, CMD_RD_RESP, 128'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 32'hF000_01F0, 2'd3, 4, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, CMD_WR_ACK, 128'h0};
    vecs[9]  = '{1'b0, 32'hF000_01F4, 2'd3, 0, 128'h0, CMD_ERR, 128'h0};
    vecs[10] = '{1'b0, 32'hF000_01F0, 2'd3, 0, 128'h0, CMD_RD_RESP, {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    vecs[11] = '{1'b0, 32'hF000_0000, 2'd0, 0, 128'h0, CMD_ERR, 128'h0};

    for (int v = 0; v < 12; v++) begin
      do_txn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].nsend,
             vecs[v].wdata, vecs[v].exp_cmd, vecs[v].exp_rdata, v % 3);
      if (v == 0) check_disp(6'd1, 32'hDEAD_BEEF);
    end
    check_disp(6'd63, 32'hA3);
    check_disp(6'd4, 32'd1);

    // Burst cut short after two of four data beats: error, first two words kept.
    do_txn("short_wr", 1'b1, 32'hF000_0120, 2'd3, 2, {32'h0, 32'h0, 32'hB2, 32'hB1}, CMD_ERR, 128'h0, 0);
    check_disp(6'd8, 32'hB1);
    check_disp(6'd9, 32'hB2);
    check_disp(6'd10, 32'h0);

    // Display port reads the old word in the cycle the bus writes it.
    bus.selin = 1'b1; bus.cmdin = CMD_WRITE; bus.addrdatain = 32'hF000_0108; bus.lenin = 2'd0;
    tick();
    bus.cmdin = CMD_IDLE; bus.addrdatain = 32'h1234_5678;
    check_disp(6'd2, mem[2]);
    tick();
    bus.selin = 1'b0; bus.addrdatain = '0;
    check("disp_after_write", disp_data, 32'h1234_5678);
    mem[2] = 32'h1234_5678;
    check_beat("disp_wr_ack", CMD_WR_ACK, 32'hF000_0108, 2'd0);
    bus.ackin = 1'b1; tick(); bus.ackin = 1'b0; tick();

    // Long stall on a read beat with a competing request that must be ignored.
    bus.selin = 1'b1; bus.cmdin = CMD_READ; bus.addrdatain = 32'hF000_0110; bus.lenin = 2'd1;
    tick();
    bus.selin = 1'b0; bus.cmdin = CMD_IDLE; bus.addrdatain = '0; bus.lenin = '0;
    for (int c = 0; c < 10; c++) begin
      check_beat($sformatf("stall c%0d", c), CMD_RD_RESP, 32'd1, 2'd1);
      if (c == 3) begin
        bus.selin = 1'b1; bus.cmdin = CMD_READ; bus.addrdatain = 32'hF000_0104; bus.lenin = 2'd0;
      end
      if (c == 5) begin
        bus.selin = 1'b0; bus.cmdin = CMD_IDLE; bus.addrdatain = '0;
      end
      tick();
    end
    bus.ackin = 1'b1;
    bus.selin = 1'b1; bus.cmdin = CMD_READ; bus.addrdatain = 32'hF000_0104;
    tick();
    bus.ackin = 1'b0; bus.selin = 1'b0; bus.cmdin = CMD_IDLE; bus.addrdatain = '0;
    check("stall gap reqout", 32'(bus.reqout), 32'h0);
    tick();
    check_beat("stall b1", CMD_RD_RESP, 32'd2, 2'd1);
    bus.ackin = 1'b1; tick(); bus.ackin = 1'b0; tick();
    check("stall done busy", 32'(busy), 32'h0);
    tick();
    check("stall no queued reqout", 32'(bus.reqout), 32'h0);

    // Ack with nothing pending is ignored.
    bus.ackin = 1'b1; tick(); bus.ackin = 1'b0;
    check("stray ack reqout", 32'(bus.reqout), 32'h0);
    check("stray ack busy", 32'(busy), 32'h0);

    // Reset in the middle of a read burst.
    bus.selin = 1'b1; bus.cmdin = CMD_READ; bus.addrdatain = 32'hF000_0110; bus.lenin = 2'd3;
    tick();
    bus.selin = 1'b0; bus.cmdin = CMD_IDLE; bus.addrdatain = '0; bus.lenin = '0;
    check_beat("rst_pre b0", CMD_RD_RESP, 32'd1, 2'd3);
    bus.ackin = 1'b1; tick(); bus.ackin = 1'b0; tick();
    check_beat("rst_pre b1", CMD_RD_RESP, 32'd2, 2'd3);
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    tick();
    check_idle_outputs("post_mid_reset");
    check_disp(6'd4, 32'h0);
    do_txn("post_rst_wr", 1'b1, 32'hF000_0114, 2'd0, 1, 128'h77, CMD_WR_ACK, 128'h0, 1);
    do_txn("post_rst_rd", 1'b0, 32'hF000_0110, 2'd1, 0, 128'h0, CMD_RD_RESP, {32'h0, 32'h0, 32'h77, 32'h0}, 0);

    // Randomized bursts against the bank model.
    for (int t = 0; t < 60; t++) begin
      wr   = 1'($urandom_range(0, 1));
      len  = 2'($urandom_range(0, 3));
      idx  = 6'($urandom_range(0, 63));
      sel  = int'($urandom_range(0, 9));
      addr = WIN + {24'h0, idx, 2'b00};
      if (sel == 0) addr = addr ^ 32'h0000_0100;
      if (sel == 1) addr[1:0] = 2'($urandom_range(1, 3));
      nsend = int'(len) + 1;
      if (wr && sel == 2) nsend = int'($urandom_range(0, int'(len)));
      wdata = {$urandom, $urandom, $urandom, $urandom};
      exp_rdata = '0;
      if (wr) exp_cmd = (nsend < int'(len) + 1 || !model_hit(addr, len)) ? CMD_ERR : CMD_WR_ACK;
      else    exp_cmd = model_hit(addr, len) ? CMD_RD_RESP : CMD_ERR;
      if (exp_cmd == CMD_RD_RESP)
        for (int b = 0; b <= int'(len); b++) exp_rdata[32*b +: 32] = mem[6'(int'(idx) + b)];
      do_txn($sformatf("rnd%0d", t), wr, addr, len, nsend, wdata, exp_cmd, exp_rdata,
             int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 64; i += 9) check_disp(6'(i), mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
